// File: rtl/hw3proc_switch_debounce.sv
// hw3proc_switch_debounce
//
// Synchronizes and debounces the raw board slide switches before they reach
// the switches PIO in_port. Each bit has a two-flop synchronizer followed by
// an independent stability counter. A synchronized bit must disagree with its
// debounced value for DEBOUNCE_CYCLES consecutive clocks before the change is
// accepted. Any shorter disagreement is thrown away.
//
// Parameters:
//   WIDTH           number of switch bits
//   DEBOUNCE_CYCLES consecutive mismatching cycles needed to accept a change (>= 1)
//   CNT_W           counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports:
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   sw_raw        raw asynchronous switch pins
//   sw_debounced  registered debounced value (drives PIO in_port)
//   sw_changed    one-cycle per-bit pulse, aligned with the sw_debounced update
//   any_changed   OR of the sw_changed bits, aligned with sw_changed

module hw3proc_switch_debounce #(
    parameter int WIDTH           = 18,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_debounced,
    output logic [WIDTH-1:0] sw_changed,
    output logic             any_changed
);

    // Count value at which the mismatch run has lasted DEBOUNCE_CYCLES cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1;
    logic [WIDTH-1:0]            sync2;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;

    logic [WIDTH-1:0][CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]            deb_nxt;
    logic [WIDTH-1:0]            chg_nxt;

    // Per-bit filter. The counter clears on the first agreeing cycle rather
    // than holding or decrementing, so only an unbroken run is ever accepted.
    // It never passes CNT_LAST, so there is no wrap-around.
    always_comb begin
        cnt_nxt = cnt;
        deb_nxt = sw_debounced;
        chg_nxt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] == sw_debounced[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt_nxt[i] = '0;
                deb_nxt[i] = sync2[i];
                chg_nxt[i] = 1'b1;
            end else begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // Synchronizer stages
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
        end
    end

    // Filter state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            sw_debounced <= '0;
            sw_changed   <= '0;
            any_changed  <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            sw_debounced <= deb_nxt;
            sw_changed   <= chg_nxt;
            any_changed  <= |chg_nxt;
        end
    end

endmodule

// File: tb/tb_hw3proc_switch_debounce.sv
module tb_hw3proc_switch_debounce;

    localparam int W = 18;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] sw_raw = '0;

    logic [W-1:0] deb4, chg4, deb1, chg1;
    logic         any4, any1;

    hw3proc_switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut4 (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
        .sw_debounced (deb4),
        .sw_changed   (chg4),
        .any_changed  (any4)
    );

    hw3proc_switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(1), .CNT_W(16)) dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .sw_raw       (sw_raw),
        .sw_debounced (deb1),
        .sw_changed   (chg1),
        .any_changed  (any1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %05h expected %05h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist holds the raw value sampled at each rising edge since reset, padded
    // with zeros (the synchronizer resets to zero). The synchronized sample
    // judged at edge k is the raw value taken two edges earlier. A bit flips
    // when the last D judged samples all disagree with its debounced value.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_deb4 = '0, m_chg4 = '0, m_deb1 = '0, m_chg1 = '0;
    logic         m_any4 = 1'b0, m_any1 = 1'b0;

    task automatic model_clear();
        hist.delete();
        for (int j = 0; j < 8; j++) hist.push_back('0);
        m_deb4 = '0; m_chg4 = '0; m_any4 = 1'b0;
        m_deb1 = '0; m_chg1 = '0; m_any1 = 1'b0;
    endtask

    function automatic logic [W-1:0] accept_mask(input int d, input logic [W-1:0] deb);
        logic [W-1:0] acc;
        int n;
        n = hist.size();
        acc = '1;
        for (int j = 0; j < d; j++)
            acc &= hist[n-2-j] ^ deb;
        return acc;
    endfunction

    always @(negedge reset_n) model_clear();

    always @(posedge clk) begin
        logic [W-1:0] a;
        if (!reset_n) begin
            model_clear();
        end else begin
            a = accept_mask(4, m_deb4);
            m_deb4 ^= a; m_chg4 = a; m_any4 = |a;
            a = accept_mask(1, m_deb1);
            m_deb1 ^= a; m_chg1 = a; m_any1 = |a;
            hist.push_back(sw_raw);
            while (hist.size() > 16) void'(hist.pop_front());
        end
    end

    // Continuous comparison, away from the active edge
    always @(negedge clk) begin
        check("deb4", deb4, m_deb4);
        check("chg4", chg4, m_chg4);
        check("any4", W'(any4), W'(m_any4));
        check("deb1", deb1, m_deb1);
        check("chg1", chg1, m_chg1);
        check("any1", W'(any1), W'(m_any1));
    end

    int pulses17 = 0;
    always @(negedge clk) if (chg4[17] === 1'b1) pulses17++;

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [9:0] BOUNCE = 10'b1111101101; // bit0 applied first

    initial begin
        edges(3);
        check("reset_deb4", deb4, '0);
        check("reset_chg4", chg4, '0);
        reset_n = 1'b1;
        edges(3);

        // Clean step on bit 0: E0 is the next rising edge
        sw_raw[0] = 1'b1;
        edges(2);
        check("min_filter_before_E2", W'(deb1[0]), W'(0));
        edges(1);
        check("min_filter_rise_E2", W'(deb1[0]), W'(1));
        edges(2);
        check("clean_before_E5", deb4, '0);
        edges(1);
        check("clean_deb_E5", deb4, 18'h00001);
        check("clean_chg_E5", chg4, 18'h00001);
        check("clean_any_E5", W'(any4), W'(1));
        edges(1);
        check("clean_chg_E6", chg4, '0);
        check("clean_any_E6", W'(any4), W'(0));

        // Glitch reject: 3-clock pulse on bit 3
        sw_raw[3] = 1'b1;
        edges(3);
        sw_raw[3] = 1'b0;
        edges(10);
        check("glitch3_deb", W'(deb4[3]), W'(0));

        // 4-clock pulse on bit 3 is accepted at E5
        sw_raw[3] = 1'b1;
        edges(4);
        sw_raw[3] = 1'b0;
        edges(1);
        check("pulse4_before_E5", W'(deb4[3]), W'(0));
        edges(1);
        check("pulse4_rise_E5", W'(deb4[3]), W'(1));
        sw_raw = '0;
        edges(12);

        // Bounce train on bit 17; final stable run starts at pattern index 5
        pulses17 = 0;
        for (int i = 0; i < 10; i++) begin
            sw_raw[17] = BOUNCE[i];
            edges(1);
        end
        check("bounce_before_E10", W'(deb4[17]), W'(0));
        edges(1);
        check("bounce_rise_E10", W'(deb4[17]), W'(1));
        edges(8);
        check("bounce_pulse_count", W'(pulses17), W'(1));

        // Simultaneous bits
        sw_raw = '0;
        edges(12);
        sw_raw = 18'h3FFFF;
        edges(6);
        check("simul_up_chg", chg4, 18'h3FFFF);
        check("simul_up_any", W'(any4), W'(1));
        edges(4);
        sw_raw = 18'h00000;
        edges(6);
        check("simul_dn_chg", chg4, 18'h3FFFF);
        check("simul_dn_deb", deb4, '0);
        edges(8);

        // Reset mid-count on bit 5, asserted between edges after E3
        sw_raw = 18'h00020;
        edges(4);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_deb4", deb4, '0);
        check("rst_mid_chg4", chg4, '0);
        check("rst_mid_deb1", deb1, '0);
        check("rst_mid_any", W'({any4, any1}), W'(0));
        edges(2);
        reset_n = 1'b1;
        edges(5);
        check("rst_rel_before", W'(deb4[5]), W'(0));
        edges(1);
        check("rst_rel_rise", W'(deb4[5]), W'(1));
        check("rst_rel_chg", chg4, 18'h00020);
        edges(4);

        // Randomized phase with bounce-like hold times and occasional resets
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) sw_raw = W'($urandom);
            else if (r < 7) sw_raw[$urandom_range(0, W-1)] ^= 1'b1;
            edges($urandom_range(1, 8));
            if ($urandom_range(0, 59) == 0) begin
                #($urandom_range(1, 4)) reset_n = 1'b0;
                edges($urandom_range(1, 3));
                reset_n = 1'b1;
            end
        end
        edges(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
